fifo_packetizer: RTL and testbench
==================================

// Module: fifo_packetizer
// PURPOSE
//  Downstream drain stage for the 8-bit sync FIFO. Pops bytes through the FIFO read port and
//  buffers up to MAX_PAYLOAD of them, then emits one framed packet on a valid/ready byte stream.
//  Frame is SOF, LEN, payload[0..LEN-1], CSUM. A short packet is flushed after TIMEOUT empty cycles.
// PARAMETERS
//  DATA_W       8      byte width; the frame format requires 8
//  MAX_PAYLOAD  4      max payload bytes per packet, legal 1..255
//  SOF_BYTE     8'hA5  start-of-frame marker byte
//  TIMEOUT      16     consecutive fifo_empty cycles in FILL (count>0) before a short flush; >=1
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  fifo_data    in   DATA_W  FIFO data_out; valid 1 cycle after fifo_rd_en (registered read)
//  fifo_empty   in   1       FIFO empty flag
//  fifo_rd_en   out  1       pop request; asserted only when fifo_empty=0
//  out_data     out  8       frame byte
//  out_valid    out  1       out_data is valid
//  out_ready    in   1       sink accepts; a beat transfers when out_valid && out_ready
//  out_last     out  1       high on the CSUM beat
//  busy         out  1       high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; count, issued, timer and csum cleared; buffer contents don't-care.
//  States: IDLE -> FILL -> SOF -> LEN -> PAY -> CSUM -> IDLE.
//  IDLE:
//   - fifo_empty=0: assert fifo_rd_en this cycle; go to FILL with issued=1.
//  FILL:
//   - Pop when fifo_empty=0 && issued<MAX_PAYLOAD. Back-to-back pops allowed.
//   - Each byte is captured into buf[count] the cycle after its pop; count increments.
//   - timer counts consecutive cycles with fifo_empty=1 and no read pending; any pop clears it.
//   - Exit to SOF when count==MAX_PAYLOAD, or when timer==TIMEOUT && count>=1 && no read pending.
//   - No pop is issued in the cycle the exit condition is met. The FIFO is never over-read.
//  SOF / LEN / PAY / CSUM:
//   - out_valid=1; state and beat index advance only on a transfer.
//   - While out_valid && !out_ready, out_data and out_last are held stable.
//   - SOF sends SOF_BYTE. LEN sends count. PAY sends buf[0..count-1] in order.
//   - CSUM sends (LEN + sum of payload bytes) mod 256, SOF excluded, and sets out_last=1.
//   - No FIFO pops occur in these states.
//  After the CSUM transfer: out_valid=0 and state returns to IDLE the next cycle.
//   - Minimum gap between frames is 1 idle cycle.
//  Latency: first pop in the cycle fifo_empty falls in IDLE.
//   - SOF is valid 1 cycle after the last payload byte is captured.
//  Boundaries:
//   - fifo_empty asserted mid-FILL: hold and wait. The timer only starts once no read is pending.
//   - Byte arriving at timer==TIMEOUT-1: that pop clears the timer; the packet grows.
//   - count never exceeds MAX_PAYLOAD. LEN is never 0; an empty FIFO never yields a frame.
//   - Checksum arithmetic is 8-bit wrapping; carries are discarded.
//   - rst mid-packet: next cycle out_valid=0, busy=0, state=IDLE.
//     Buffered, already-popped bytes are dropped; no partial frame resumes.
//   - out_ready is ignored when out_valid=0.
// TESTING (MAX_PAYLOAD=4, TIMEOUT=16, SOF=A5)
//  1 Full packet: FIFO holds 11,22,33,44, out_ready=1
//    -> stream A5,04,11,22,33,44,AE with out_last on AE; exactly 4 pops.
//  2 Short flush: push 01,02 then nothing
//    -> after 16 empty cycles, stream A5,02,01,02,05; no further pops.
//  3 Wrap: push FF,FF,FF,FF -> CSUM=00.
//    Then push 8 bytes -> two back-to-back frames, each LEN=04, with a 1-cycle gap.
//  4 Backpressure: case 1 with out_ready toggling 1,0,0,1,...
//    -> byte sequence identical; out_data stable during stalls; no drops or duplicates.
//  5 Reset at the PAY beat (byte 22) -> out_valid=0 next cycle.
//    Subsequent push 55 plus timeout -> clean A5,01,55,56.
//  6 FIFO empty forever after reset -> fifo_rd_en=0, out_valid=0, busy=0 for 100 cycles.

Source files
------------

// File: rtl/fifo_packetizer.sv
// fifo_packetizer: drains the byte FIFO into SOF/LEN/payload/CSUM frames on a valid/ready stream.
module fifo_packetizer #(
  parameter int         DATA_W      = 8,
  parameter int         MAX_PAYLOAD = 4,
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_SOF  = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
  localparam logic [2:0] S_CSUM = 3'd5;
  localparam int AW = MAX_PAYLOAD > 1 ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAXP = 8'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic [7:0]    count_q, count_d, issued_q, issued_d, idx_q, idx_d, csum_q, csum_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_q, pend_d;
  logic [7:0]    pay_q [MAX_PAYLOAD];
  logic [7:0]    pay_d [MAX_PAYLOAD];
  logic          pop, fire, full, tmo;

  assign out_valid  = state_q >= S_SOF && state_q <= S_CSUM;
  assign out_last   = state_q == S_CSUM;
  assign busy       = state_q != S_IDLE;
  assign fifo_rd_en = pop && !rst;
  assign out_data   = state_q == S_SOF  ? SOF_BYTE :
                      state_q == S_LEN  ? count_q :
                      state_q == S_PAY  ? pay_q[idx_q[AW-1:0]] :
                      state_q == S_CSUM ? csum_q + count_q : 8'd0;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    issued_d = issued_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    timer_d  = timer_q;
    pay_d    = pay_q;
    pop      = 1'b0;
    fire     = out_valid && out_ready;
    // the byte landing this cycle is the last one the packet can hold
    full     = pend_q && (count_q + 8'd1 == MAXP);
    tmo      = timer_q == TMAX && count_q != 8'd0 && !pend_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        pop      = 1'b1;
        issued_d = 8'd1;
        state_d  = S_FILL;
      end
      S_FILL: begin
        if (pend_q) begin
          pay_d[count_q[AW-1:0]] = fifo_data;
          count_d = count_q + 8'd1;
          csum_d  = csum_q + fifo_data;
        end
        if (full || tmo) state_d = S_SOF;
        else if (!fifo_empty && issued_q < MAXP) begin
          pop      = 1'b1;
          issued_d = issued_q + 8'd1;
        end
        timer_d = (pop || pend_q || !fifo_empty) ? '0 : (timer_q == TMAX ? timer_q : timer_q + 1'b1);
      end
      S_SOF: state_d = fire ? S_LEN : state_q;
      S_LEN: if (fire) begin
        state_d = S_PAY;
        idx_d   = 8'd0;
      end
      S_PAY: if (fire) begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q + 8'd1 == count_q) ? S_CSUM : S_PAY;
      end
      S_CSUM: if (fire) begin
        state_d  = S_IDLE;
        count_d  = 8'd0;
        issued_d = 8'd0;
        csum_d   = 8'd0;
        timer_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
    pend_d = pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= 8'd0;
      issued_q <= 8'd0;
      idx_q    <= 8'd0;
      csum_q   <= 8'd0;
      timer_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk) pay_q <= pay_d;
endmodule

// File: tb/tb_fifo_packetizer.sv
// tb_fifo_packetizer: drives a FIFO model into the packetizer and checks frames against a frame-building model.
module tb_fifo_packetizer;
  localparam int MAXP = 4;
  localparam int TMO = 16;
  localparam logic [7:0] SOF = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'd0;
  logic fifo_rd_en, out_valid, out_last, busy;
  logic out_ready = 1'b0;
  logic [7:0] out_data;

  fifo_packetizer #(.DATA_W(8), .MAX_PAYLOAD(MAXP), .SOF_BYTE(SOF), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pop_cnt = 0, ovr_cnt = 0, stall_err = 0, gap_err = 0;
  int rmode = 0, push_cyc = 0, last_base = 0;
  logic [7:0] fq[$];
  logic [7:0] inq[$];
  logic [7:0] stim[$];
  logic [8:0] got[$];
  int got_t[$];
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0, plx = 1'b0;
  logic [7:0] pd = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() == 0) ovr_cnt <= ovr_cnt + 1;
      else begin
        fifo_data <= fq.pop_front();
        pop_cnt <= pop_cnt + 1;
      end
    end
    while (inq.size() > 0) fq.push_back(inq.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  always @(posedge clk) begin
    #1;
    out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) stall_err++;
      if (plx && out_valid) gap_err++;
      if (out_valid && out_ready) begin
        got.push_back({out_last, out_data});
        got_t.push_back(cyc);
      end
    end
    pv = out_valid && !rst;
    pr = out_ready;
    pd = out_data;
    pl = out_last;
    plx = out_valid && out_ready && out_last && !rst;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frames(input string name);
    logic [8:0] exp[$];
    logic [7:0] s;
    int base, p0, o0, s0, g0, k, n;
    k = 0;
    while (k < stim.size()) begin
      n = (stim.size() - k < MAXP) ? stim.size() - k : MAXP;
      exp.push_back({1'b0, SOF});
      exp.push_back({1'b0, 8'(n)});
      s = 8'(n);
      for (int i = 0; i < n; i++) begin
        exp.push_back({1'b0, stim[k+i]});
        s = s + stim[k+i];
      end
      exp.push_back({1'b1, s});
      k += n;
    end
    base = got.size();
    last_base = base;
    p0 = pop_cnt; o0 = ovr_cnt; s0 = stall_err; g0 = gap_err;
    foreach (stim[i]) inq.push_back(stim[i]);
    push_cyc = cyc;
    for (int t = 0; t < 3000 && got.size() - base < exp.size(); t++) step(1);
    step(40);
    n_cmp++;
    if (got.size() - base !== exp.size()) begin
      n_bad++;
      $display("FAIL %s beats: got %0d want %0d", name, got.size() - base, exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size() - base) begin
        n_cmp++;
        if (got[base+i] !== exp[i]) begin
          n_bad++;
          $display("FAIL %s beat%0d: got last=%b %h want last=%b %h", name, i,
                   got[base+i][8], got[base+i][7:0], exp[i][8], exp[i][7:0]);
        end
      end
    end
    n_cmp++;
    if (pop_cnt - p0 !== stim.size()) begin
      n_bad++;
      $display("FAIL %s pops: got %0d want %0d", name, pop_cnt - p0, stim.size());
    end
    n_cmp++;
    if (ovr_cnt - o0 + stall_err - s0 + gap_err - g0 !== 0) begin
      n_bad++;
      $display("FAIL %s protocol: overread=%0d stall=%0d gap=%0d want 0", name, ovr_cnt - o0, stall_err - s0, gap_err - g0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_last, busy, fifo_rd_en, out_data} !== 12'd0) begin
      n_bad++;
      $display("FAIL reset: got valid=%b last=%b busy=%b rd=%b data=%h want all 0",
               out_valid, out_last, busy, fifo_rd_en, out_data);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_full_packet();
    rmode = 0;
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frames("full");
  endtask

  task automatic test_short_flush();
    rmode = 0;
    stim = '{8'h01, 8'h02};
    run_frames("short");
    n_cmp++;
    if (last_base >= got_t.size() || got_t[last_base] - push_cyc <= TMO) begin
      n_bad++;
      $display("FAIL short_latency: got %0d cycles want > %0d",
               last_base < got_t.size() ? got_t[last_base] - push_cyc : -1, TMO);
    end
  endtask

  task automatic test_back_to_back();
    rmode = 0;
    stim = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frames("wrap");
    stim = {};
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    run_frames("b2b");
  endtask

  task automatic test_backpressure();
    rmode = 1;
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frames("bp");
    rmode = 0;
  endtask

  task automatic test_reset_mid();
    int base;
    bit seen;
    rmode = 0;
    seen = 0;
    foreach (stim[i]) stim.delete(i);
    inq.push_back(8'h11); inq.push_back(8'h22); inq.push_back(8'h33); inq.push_back(8'h44);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (out_valid && out_data == 8'h22 && !out_last) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL mid_wait: got no 22 beat want one within 300 cycles");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_reset: got valid=%b busy=%b want 0 0", out_valid, busy);
    end
    rst = 1'b0;
    base = got.size();
    step(30);
    n_cmp++;
    if (got.size() !== base || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_resume: got %0d beats busy=%b want 0 beats busy=0", got.size() - base, busy);
    end
    stim = '{8'h55};
    run_frames("after_rst");
  endtask

  task automatic test_idle_empty();
    int bad;
    bad = 0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({fifo_rd_en, out_valid, busy} !== 3'b000) begin
        n_bad++;
        bad++;
        if (bad < 4) $display("FAIL idle_empty: got rd=%b valid=%b busy=%b want 0 0 0", fifo_rd_en, out_valid, busy);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      rmode = $urandom_range(0, 2);
      n = $urandom_range(1, 10);
      stim = {};
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      run_frames("rand");
    end
    rmode = 0;
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_short_flush();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_idle_empty();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
